// File: rtl/credential_check.sv
// Keypad credential checker: collects a BCD account number, scans a fixed four-entry table, then verifies the PIN.
// Optional feature macro: LOCKOUT_EN adds a per-account consecutive wrong-PIN lockout.
`default_nettype none

module credential_check #(
  parameter int ACC_DIGITS   = 4,
  parameter int PIN_DIGITS   = 4,
  parameter int NUM_ACCOUNTS = 4,
  parameter int MAX_TRIES    = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] input_style,
  input  logic       key_valid,
  input  logic [3:0] key_code,
  output logic [3:0] status_code,
  output logic       status_valid,
  output logic       acc_valid,
  output logic [1:0] acc_index,
  output logic [2:0] digit_count,
  output logic       busy
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_COLLECT_ACC,
    S_LOOKUP,
    S_COLLECT_PIN,
    S_CHECK_PIN
  } state_e;

  localparam logic [3:0] STYLE_ACC = 4'd2;
  localparam logic [3:0] STYLE_PIN = 4'd3;
  localparam logic [3:0] KEY_CLEAR = 4'hA;
  localparam logic [3:0] KEY_ENTER = 4'hB;

  localparam logic [3:0] ST_NONE          = 4'd0;
  localparam logic [3:0] ST_ACC_FOUND     = 4'd1;
  localparam logic [3:0] ST_ACC_NOT_FOUND = 4'd2;
  localparam logic [3:0] ST_PIN_CORRECT   = 4'd3;
  localparam logic [3:0] ST_PIN_INCORRECT = 4'd4;

  function automatic logic [15:0] acc_entry(input logic [1:0] idx);
    logic [15:0] v;
    case (idx)
      2'd0:    v = 16'h1001;
      2'd1:    v = 16'h2002;
      2'd2:    v = 16'h3003;
      default: v = 16'h4004;
    endcase
    return v;
  endfunction

  function automatic logic [15:0] pin_entry(input logic [1:0] idx);
    logic [15:0] v;
    case (idx)
      2'd0:    v = 16'h1111;
      2'd1:    v = 16'h2222;
      2'd2:    v = 16'h3333;
      default: v = 16'h4444;
    endcase
    return v;
  endfunction

  state_e      state_q;
  logic [15:0] buf_q;
  logic [2:0]  cnt_q;
  logic [3:0]  status_q;
  logic        acc_valid_q;
  logic [1:0]  acc_idx_q;
  logic        busy_q;
  logic [2:0]  scan_q;
  logic        hit_q;
  logic [1:0]  hit_idx_q;

  logic        is_digit, is_clear, is_enter;
  logic        abort, session_end;
  logic [2:0]  digit_limit;
  logic [15:0] buf_d;
  logic        entry_locked;
  logic        entry_hit;
  logic        pin_ok;
  logic        pin_check_fire;

  // NOTE: every signal assigned in always_comb gets a value on every path,
  // otherwise synthesis infers a latch to hold the old value.
  always_comb begin
    is_digit    = key_valid && (key_code <= 4'd9);
    is_clear    = key_valid && (key_code == KEY_CLEAR);
    is_enter    = key_valid && (key_code == KEY_ENTER);
    session_end = (input_style != STYLE_ACC) && (input_style != STYLE_PIN);
    digit_limit = (state_q == S_COLLECT_PIN) ? 3'(PIN_DIGITS) : 3'(ACC_DIGITS);
    buf_d       = {buf_q[11:0], key_code};
    abort       = 1'b0;
    case (state_q)
      S_COLLECT_ACC, S_LOOKUP:   abort = (input_style != STYLE_ACC);
      S_COLLECT_PIN, S_CHECK_PIN: abort = (input_style != STYLE_PIN);
      default:                   abort = 1'b0;
    endcase
    entry_hit      = (buf_q == acc_entry(scan_q[1:0])) && !entry_locked;
    pin_ok         = (cnt_q == 3'(PIN_DIGITS)) && (buf_q == pin_entry(acc_idx_q));
    pin_check_fire = (state_q == S_CHECK_PIN) && !abort;
  end

`ifdef LOCKOUT_EN
  logic [1:0] fail_cnt_q [NUM_ACCOUNTS];

  // NOTE: this small counter array is reset explicitly because a lockout must be
  // released by rst; large storage arrays would normally be left unreset.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_ACCOUNTS; i++) fail_cnt_q[i] <= '0;
    end else if (pin_check_fire) begin
      if (pin_ok)
        fail_cnt_q[acc_idx_q] <= '0;
      else if (fail_cnt_q[acc_idx_q] != 2'(MAX_TRIES))
        fail_cnt_q[acc_idx_q] <= fail_cnt_q[acc_idx_q] + 2'd1;
    end
  end

  assign entry_locked = (fail_cnt_q[scan_q[1:0]] == 2'(MAX_TRIES));
`else
  logic unused_cfg;
  assign unused_cfg   = (MAX_TRIES != 0) && pin_check_fire;
  assign entry_locked = 1'b0;
`endif

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      buf_q       <= '0;
      cnt_q       <= '0;
      status_q    <= ST_NONE;
      acc_valid_q <= 1'b0;
      acc_idx_q   <= '0;
      busy_q      <= 1'b0;
      scan_q      <= '0;
      hit_q       <= 1'b0;
      hit_idx_q   <= '0;
    end else begin
      status_q <= ST_NONE;
      if (session_end) acc_valid_q <= 1'b0;

      if (abort) begin
        state_q <= S_IDLE;
        buf_q   <= '0;
        cnt_q   <= '0;
        busy_q  <= 1'b0;
      end else begin
        case (state_q)
          S_IDLE: begin
            if (input_style == STYLE_ACC)
              state_q <= S_COLLECT_ACC;
            else if (input_style == STYLE_PIN && acc_valid_q)
              state_q <= S_COLLECT_PIN;
          end

          S_COLLECT_ACC, S_COLLECT_PIN: begin
            if (is_clear) begin
              buf_q <= '0;
              cnt_q <= '0;
            end else if (is_digit) begin
              if (cnt_q < digit_limit) begin
                buf_q <= buf_d;
                cnt_q <= cnt_q + 3'd1;
              end
            end else if (is_enter) begin
              busy_q <= 1'b1;
              if (state_q == S_COLLECT_PIN) begin
                state_q <= S_CHECK_PIN;
              end else begin
                // A short entry rides the final LOOKUP step so its miss lands one cycle later.
                state_q <= S_LOOKUP;
                hit_q   <= 1'b0;
                scan_q  <= (cnt_q == 3'(ACC_DIGITS)) ? 3'd0 : 3'(NUM_ACCOUNTS);
              end
            end
          end

          S_LOOKUP: begin
            if (scan_q == 3'(NUM_ACCOUNTS)) begin
              busy_q <= 1'b0;
              buf_q  <= '0;
              cnt_q  <= '0;
              if (hit_q) begin
                status_q    <= ST_ACC_FOUND;
                acc_valid_q <= 1'b1;
                acc_idx_q   <= hit_idx_q;
                state_q     <= S_IDLE;
              end else begin
                status_q <= ST_ACC_NOT_FOUND;
                state_q  <= S_COLLECT_ACC;
              end
            end else begin
              scan_q <= scan_q + 3'd1;
              if (entry_hit) begin
                hit_q     <= 1'b1;
                hit_idx_q <= scan_q[1:0];
              end
            end
          end

          S_CHECK_PIN: begin
            busy_q  <= 1'b0;
            buf_q   <= '0;
            cnt_q   <= '0;
            state_q <= S_IDLE;
            if (pin_ok) begin
              status_q <= ST_PIN_CORRECT;
            end else begin
              status_q    <= ST_PIN_INCORRECT;
              acc_valid_q <= 1'b0;
            end
          end

          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  assign status_code  = status_q;
  assign status_valid = (status_q != ST_NONE);
  assign acc_valid    = acc_valid_q;
  assign acc_index    = acc_idx_q;
  assign digit_count  = cnt_q;
  assign busy         = busy_q;

endmodule

`default_nettype wire
